// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters; 3 cycles per attempt (grant, write, response).
// Stalls in IDLE while fifo_full; overflowed writes are retried with priority kept, then dropped after MAX_RETRY attempts.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_RETRY  = 3,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            drop,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          busy,
    output logic [CNT_W-1:0]              wr_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       gidx_q;
    logic [RTY_W-1:0]       retry_q;
    logic [CNT_W-1:0]       wr_count_q;
    logic [FIFO_WIDTH-1:0]  data_q;
    logic                   wr_en_q;

    logic [FIFO_WIDTH-1:0]  words [NUM_REQ];
    logic                   sel_vld;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       next_ptr;
    logic                   resp_ovf;
    logic                   last_try;
    logic                   finish;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign words[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // Search starts at rr_ptr and wraps, so the last-served requester goes to the back of the line.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            cand = IDX_W'(j);
            if (!sel_vld && req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // A response with neither flag set is handled as an overflow.
    assign resp_ovf = fifo_overflow | ~fifo_wr_ack;
    assign last_try = (retry_q == RTY_W'(MAX_RETRY - 1));
    assign finish   = (state_q == RESP) && (fifo_wr_ack || (resp_ovf && last_try));
    assign next_ptr = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            retry_q    <= '0;
            wr_count_q <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_vld && !fifo_full) begin
                        gidx_q  <= sel_idx;
                        data_q  <= words[sel_idx];
                        wr_en_q <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    wr_en_q <= 1'b0;
                    state_q <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                    if (fifo_wr_ack) begin
                        wr_count_q <= wr_count_q + CNT_W'(1);
                        retry_q    <= '0;
                        rr_ptr_q   <= next_ptr;
                    end else if (resp_ovf && last_try) begin
                        retry_q  <= '0;
                        rr_ptr_q <= next_ptr;
                    end else begin
                        retry_q <= retry_q + RTY_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign done         = finish ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gidx_q) : '0;
    assign drop         = (finish && !fifo_wr_ack) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gidx_q) : '0;
    assign fifo_data_in = data_q;
    assign fifo_wr_en   = wr_en_q;
    assign busy         = (state_q != IDLE);
    assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester queues, a FIFO responder and an expected-completion queue.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int W  = 16;
    localparam int MR = 3;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] req_data = '0;
    logic [NR-1:0]   done;
    logic [NR-1:0]   drop;
    logic [W-1:0]    fifo_data_in;
    logic            fifo_wr_en;
    logic            fifo_full = 1'b0;
    logic            fifo_wr_ack = 1'b0;
    logic            fifo_overflow = 1'b0;
    logic            busy;
    logic [CW-1:0]   wr_count;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(W), .MAX_RETRY(MR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .done(done), .drop(drop), .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
        .busy(busy), .wr_count(wr_count)
    );

    typedef struct {
        int          idx;
        logic [W-1:0] data;
        bit          drp;
    } exp_t;

    exp_t          sb_q[$];
    logic [W-1:0]  words [NR][16];
    int            head [NR];
    int            tail [NR];
    logic [NR-1:0] force_req = '0;
    logic          ovf_all = 1'b0;
    logic          wen_seen = 1'b0;
    logic [W-1:0]  last_wr_data = '0;
    int n_checks = 0, n_fail = 0;
    int cyc = 0, wr_pulses = 0, wr_cyc = 0, done_cyc = 0, first_done_cyc = 0, n_done = 0, req_rise_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input int i, input logic [W-1:0] d);
        words[i][tail[i]] = d;
        tail[i]++;
    endtask

    task automatic sb_expect(input int i, input logic [W-1:0] d, input bit drp);
        exp_t e;
        e.idx = i; e.data = d; e.drp = drp;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb_q.size(), 0);
    endtask

    // FIFO model: answers each write one cycle after wr_en, overflowing when ovf_all is set.
    always @(posedge clk) begin
        #1;
        fifo_wr_ack   = wen_seen & ~ovf_all;
        fifo_overflow = wen_seen & ovf_all;
    end

    // Monitor, scoreboard compare and requester model (holds req/data until its done).
    always @(negedge clk) begin
        exp_t          e;
        logic [NR-1:0] nreq;
        cyc++;
        wen_seen = fifo_wr_en;
        if (!rst) begin
            if (fifo_wr_en) begin
                wr_pulses++;
                wr_cyc = cyc;
                last_wr_data = fifo_data_in;
            end
            if (done != '0) begin
                done_cyc = cyc;
                if (n_done == 0) first_done_cyc = cyc;
                n_done++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_vec", done, 1 << e.idx);
                    check("drop_vec", drop, e.drp ? (1 << e.idx) : 0);
                    check("wr_data", last_wr_data, e.data);
                end
                for (int i = 0; i < NR; i++) begin
                    if (done[i] && head[i] < tail[i]) head[i]++;
                end
            end
        end
        nreq = force_req;
        for (int i = 0; i < NR; i++) begin
            if (head[i] < tail[i]) begin
                nreq[i] = 1'b1;
                req_data[i*W +: W] = words[i][head[i]];
            end
        end
        if (req == '0 && nreq != '0) req_rise_cyc = cyc;
        req = nreq;
    end

    initial begin
        int p;
        int n;
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        force_req = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            check("rst_wr_en", fifo_wr_en, 0);
            check("rst_done", done, 0);
            check("rst_busy", busy, 0);
            check("rst_wr_count", wr_count, 0);
        end
        force_req = '0;
        @(negedge clk);
        rst = 1'b0;

        // Round robin: all four requesters hold two words each.
        n_done = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) begin
                push_req(i, W'(16'h1000 + r * 16 + i));
                sb_expect(i, W'(16'h1000 + r * 16 + i), 1'b0);
            end
        end
        wait_drain(80);
        check("rr_period", done_cyc - first_done_cyc, 21);
        check("rr_count", wr_count, 8);

        // Single requester latency.
        @(posedge clk);
        #1;
        push_req(2, 16'hA5A5);
        sb_expect(2, 16'hA5A5, 1'b0);
        wait_drain(20);
        check("single_lat_wr", wr_cyc - req_rise_cyc, 1);
        check("single_lat_done", done_cyc - wr_cyc, 1);
        check("single_count", wr_count, 9);

        // Full stall, then release.
        @(negedge clk);
        fifo_full = 1'b1;
        p = wr_pulses;
        push_req(0, 16'h0F0F);
        sb_expect(0, 16'h0F0F, 1'b0);
        repeat (6) @(negedge clk);
        check("full_no_wr", wr_pulses, p);
        check("full_busy", busy, 0);
        fifo_full = 1'b0;
        @(negedge clk);
        check("full_release_wr", fifo_wr_en, 1);
        wait_drain(20);
        check("full_count", wr_count, 10);

        // Persistent overflow: MAX_RETRY attempts then drop.
        ovf_all = 1'b1;
        p = wr_pulses;
        push_req(1, 16'h5A5A);
        sb_expect(1, 16'h5A5A, 1'b1);
        wait_drain(40);
        check("ovf_pulses", wr_pulses - p, MR);
        check("ovf_count", wr_count, 10);
        ovf_all = 1'b0;

        // Reset during WRITE: rr_ptr is 2 so requester 3 wins first; after reset requester 0 wins.
        push_req(0, 16'h0C0C);
        push_req(3, 16'h3C3C);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_wr_en && n < 20);
        check("mid_wr_seen", fifo_wr_en, 1);
        check("mid_grant_data", fifo_data_in, 16'h3C3C);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_en", fifo_wr_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_count", wr_count, 0);
        rst = 1'b0;
        sb_expect(0, 16'h0C0C, 1'b0);
        sb_expect(3, 16'h3C3C, 1'b0);
        wait_drain(30);
        check("mid_after_count", wr_count, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
